// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: load/store codes,
// FSM states, byte-enable constants and small decode helpers.
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        LDST_LB  = 3'b000,
        LDST_LH  = 3'b001,
        LDST_LW  = 3'b010,
        LDST_LBU = 3'b011,
        LDST_LHU = 3'b100,
        LDST_SB  = 3'b101,
        LDST_SH  = 3'b110,
        LDST_SW  = 3'b111
    } ldst_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [3:0] WE_NONE = 4'b0000;
    localparam logic [3:0] WE_ALL  = 4'b1111;

    function automatic logic is_store(input ldst_e op);
        return op inside {LDST_SB, LDST_SH, LDST_SW};
    endfunction

    // Halves need a[0]=0, words need a=0.
    function automatic logic is_misaligned(input ldst_e op, input logic [1:0] a);
        if (op inside {LDST_LH, LDST_LHU, LDST_SH}) return a[0];
        if (op inside {LDST_LW, LDST_SW})           return a != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// Combinational byte-lane steering: store byte enables / replicated store data
// and sign/zero extension of load data, little-endian.
module mem_port_arbiter_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  ldst_e       ldst,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  we,
    output logic [31:0] wdata_al,
    output logic [31:0] rdata_ext
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        // NOTE: every combinational output is given a default first so no path infers a latch.
        we        = WE_NONE;
        wdata_al  = wdata;
        rdata_ext = rdata;
        lane_byte = rdata[7:0];
        case (a)
            2'd1:    lane_byte = rdata[15:8];
            2'd2:    lane_byte = rdata[23:16];
            2'd3:    lane_byte = rdata[31:24];
            default: lane_byte = rdata[7:0];
        endcase
        lane_half = a[1] ? rdata[31:16] : rdata[15:0];

        case (ldst)
            LDST_LB:  rdata_ext = {{24{lane_byte[7]}}, lane_byte};
            LDST_LH:  rdata_ext = {{16{lane_half[15]}}, lane_half};
            LDST_LBU: rdata_ext = {24'd0, lane_byte};
            LDST_LHU: rdata_ext = {16'd0, lane_half};
            LDST_SB: begin
                we       = 4'b0001 << a;
                wdata_al = {4{wdata[7:0]}};
            end
            LDST_SH: begin
                we       = a[1] ? 4'b1100 : 4'b0011;
                wdata_al = {2{wdata[15:0]}};
            end
            LDST_SW:  we = WE_ALL;
            default:  rdata_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Optional build macro MEM_MISALIGN_TRAP_EN adds dm_misalign and suppresses misaligned accesses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DATA_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          dm_req,
    input  logic [AW-1:0] dm_addr,
    input  logic [2:0]    dm_ldst,
    input  logic [31:0]   dm_wdata,
    output logic          dm_done,
    output logic [31:0]   dm_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic          dm_misalign,
`endif
    output logic          stall,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_we,
    output logic [31:0]   mem_wdata,
    input  logic          mem_rvalid,
    input  logic [31:0]   mem_rdata
);

    localparam int                  STREAK_W   = $clog2(DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(DATA_STREAK);

    state_e              state;
    logic                owner_dm;
    ldst_e               ldst_q;
    logic [1:0]          a_q;
    logic [STREAK_W-1:0] streak;

    logic        grant_dm, grant_if, trap;
    ldst_e       sel_ldst;
    logic [1:0]  sel_a;
    logic [3:0]  al_we;
    logic [31:0] al_wdata, al_rdata;

    // Data wins ties unless IF has already waited out a full data streak.
    assign grant_dm = dm_req && !(if_req && streak == STREAK_MAX);
    assign grant_if = if_req && !grant_dm;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = grant_dm && is_misaligned(ldst_e'(dm_ldst), dm_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // Live request fields steer stores at grant time; latched fields extend load data.
    assign sel_ldst = (state == S_IDLE) ? ldst_e'(dm_ldst) : ldst_q;
    assign sel_a    = (state == S_IDLE) ? dm_addr[1:0] : a_q;

    mem_port_arbiter_lane_align u_lane_align (
        .ldst      (sel_ldst),
        .a         (sel_a),
        .wdata     (dm_wdata),
        .rdata     (mem_rdata),
        .we        (al_we),
        .wdata_al  (al_wdata),
        .rdata_ext (al_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: all state, including the output registers, updates with <= and clears on async reset.
        if (rst) begin
            state     <= S_IDLE;
            owner_dm  <= 1'b0;
            ldst_q    <= LDST_LB;
            a_q       <= 2'b00;
            streak    <= '0;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= WE_NONE;
            mem_wdata <= '0;
            stall     <= 1'b0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            dm_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_dm)
                        streak <= if_req ? streak + 1'b1 : '0;
                    else
                        streak <= '0;

                    if (trap) begin
                        state   <= S_DONE;
                        dm_done <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                        dm_misalign <= 1'b1;
`endif
                    end else if (grant_dm || grant_if) begin
                        state     <= S_ISSUE;
                        owner_dm  <= grant_dm;
                        ldst_q    <= ldst_e'(dm_ldst);
                        a_q       <= grant_dm ? dm_addr[1:0] : if_addr[1:0];
                        mem_valid <= 1'b1;
                        stall     <= 1'b1;
                        mem_addr  <= grant_dm ? {dm_addr[AW-1:2], 2'b00}
                                              : {if_addr[AW-1:2], 2'b00};
                        mem_we    <= grant_dm ? al_we : WE_NONE;
                        mem_wdata <= al_wdata;
                    end
                end
                S_ISSUE: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        mem_we    <= WE_NONE;
                        if (owner_dm && is_store(ldst_q)) begin
                            state   <= S_DONE;
                            stall   <= 1'b0;
                            dm_done <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        state <= S_DONE;
                        stall <= 1'b0;
                        if (owner_dm) begin
                            dm_done  <= 1'b1;
                            dm_rdata <= al_rdata;
                        end else begin
                            if_done  <= 1'b1;
                            if_rdata <= mem_rdata;
                        end
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                    dm_misalign <= 1'b0;
`endif
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// single accesses against a word-level reference memory. Honors MEM_MISALIGN_TRAP_EN.
module tb_mem_port_arbiter;

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    localparam int LIMIT = 60;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [2:0]  dm_ldst;
    logic        if_done, dm_done, stall;
    logic [31:0] if_rdata, dm_rdata;
    logic        mem_valid, mem_ready, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        dm_misalign;
`endif

    mem_port_arbiter #(.AW(32), .DATA_STREAK(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_done    (if_done),
        .if_rdata   (if_rdata),
        .dm_req     (dm_req),
        .dm_addr    (dm_addr),
        .dm_ldst    (dm_ldst),
        .dm_wdata   (dm_wdata),
        .dm_done    (dm_done),
        .dm_rdata   (dm_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .dm_misalign(dm_misalign),
`endif
        .stall      (stall),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Physical memory (written by the DUT) and reference memory (written by the model).
    logic [31:0] phys [logic [31:0]];
    logic [31:0] refm [logic [31:0]];

    function automatic logic [31:0] seed_word(input logic [31:0] wa);
        return (wa * 32'h9E3779B1) ^ 32'hA5A51234;
    endfunction

    function automatic logic [31:0] phys_rd(input logic [31:0] wa);
        return phys.exists(wa) ? phys[wa] : seed_word(wa);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] wa);
        return refm.exists(wa) ? refm[wa] : seed_word(wa);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] w = old;
        for (int i = 0; i < 4; i++)
            if (we[i]) w[8*i +: 8] = wd[8*i +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [31:0] b = (w >> (8 * a)) & 32'hFF;
        logic [31:0] h = (a >= 2) ? (w >> 16) : (w & 32'hFFFF);
        case (op)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd3:    return b;
            3'd4:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] ref_we(input logic [2:0] op, input logic [1:0] a);
        if (op == 3'd5) return 4'(1 << a);
        if (op == 3'd6) return (a >= 2) ? 4'hC : 4'h3;
        if (op == 3'd7) return 4'hF;
        return 4'h0;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] op, input logic [31:0] wd);
        if (op == 3'd5) return (wd & 32'hFF) * 32'h01010101;
        if (op == 3'd6) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic bit misaligned(input logic [2:0] op, input logic [1:0] a);
        return ((op == 3'd1 || op == 3'd4 || op == 3'd6) && a[0]) ||
               ((op == 3'd2 || op == 3'd7) && a != 2'b00);
    endfunction

    // Memory responder: holds mem_ready low for ready_wait cycles, returns reads rv_lat later.
    int unsigned ready_wait = 0;
    int unsigned rv_lat = 1;
    int unsigned acc_cnt = 0;
    int unsigned pend = 0;
    int unsigned wctr = 0;
    logic [31:0] pend_data;

    initial begin
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pend_data;
                end
            end
            mem_ready = 1'b0;
            if (mem_valid === 1'b1) begin
                if (wctr < ready_wait) begin
                    wctr++;
                end else begin
                    mem_ready = 1'b1;
                    wctr = 0;
                    acc_cnt++;
                    if (mem_we == 4'h0) begin
                        pend      = rv_lat;
                        pend_data = phys_rd(mem_addr);
                    end else begin
                        phys[mem_addr] = merge(phys_rd(mem_addr), mem_we, mem_wdata);
                    end
                end
            end
        end
    end

    logic [3:0]  last_we;
    logic [31:0] last_wd;

    task automatic do_dm(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input int unsigned w, input int unsigned rl);
        logic [1:0]  a     = addr[1:0];
        bit          st    = (op >= 3'd5);
        bit          mis   = TRAP && misaligned(op, addr[1:0]);
        logic [31:0] waddr = {addr[31:2], 2'b00};
        logic [3:0]  ewe   = ref_we(op, addr[1:0]);
        logic [31:0] ewd   = ref_wd(op, wd);
        logic [31:0] erd   = ref_load(op, a, ref_rd(waddr));
        int          exp_lat;
        int          k;
        int unsigned acc0;
        ready_wait = w;
        rv_lat     = rl;
        acc0       = acc_cnt;
        exp_lat    = mis ? 1 : (st ? 2 + int'(w) : 2 + int'(w) + int'(rl));
        dm_addr  = addr;
        dm_ldst  = op;
        dm_wdata = wd;
        dm_req   = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k <= exp_lat) check("stall", {31'd0, stall}, {31'd0, k < exp_lat});
            if (mem_valid === 1'b1) begin
                last_we = mem_we;
                last_wd = mem_wdata;
                check("mem_addr", mem_addr, waddr);
                check("mem_we", {28'd0, mem_we}, {28'd0, ewe});
                if (st) check("mem_wdata", mem_wdata, ewd);
            end
        end while (dm_done !== 1'b1 && k < LIMIT);
        dm_req = 1'b0;
        check("dm_latency", k, exp_lat);
        check("dm_if_done_quiet", {31'd0, if_done}, 32'd0);
        if (!st && !mis) check("dm_rdata", dm_rdata, erd);
`ifdef MEM_MISALIGN_TRAP_EN
        check("dm_misalign", {31'd0, dm_misalign}, {31'd0, mis});
`endif
        check("mem_accepts", acc_cnt - acc0, mis ? 0 : 1);
        if (st && !mis) refm[waddr] = merge(ref_rd(waddr), ewe, ewd);
        @(negedge clk);
        check("dm_done_pulse", {31'd0, dm_done}, 32'd0);
    endtask

    task automatic do_if(input logic [31:0] addr, input int unsigned w, input int unsigned rl);
        int exp_lat = 2 + int'(w) + int'(rl);
        int k = 0;
        ready_wait = w;
        rv_lat     = rl;
        if_addr = addr;
        if_req  = 1'b1;
        do begin
            @(negedge clk);
            k++;
            if (mem_valid === 1'b1) begin
                check("if_mem_addr", mem_addr, addr);
                check("if_mem_we", {28'd0, mem_we}, 32'd0);
            end
        end while (if_done !== 1'b1 && k < LIMIT);
        if_req = 1'b0;
        check("if_latency", k, exp_lat);
        check("if_rdata", if_rdata, ref_rd(addr));
        check("if_dm_done_quiet", {31'd0, dm_done}, 32'd0);
        @(negedge clk);
        check("if_done_pulse", {31'd0, if_done}, 32'd0);
    endtask

    initial begin
        int k;
        int nev;
        bit seen;
        rst = 1'b1;
        if_req = 1'b0; dm_req = 1'b0;
        if_addr = '0; dm_addr = '0; dm_ldst = '0; dm_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_we", {28'd0, mem_we}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_if_done", {31'd0, if_done}, 32'd0);
        check("rst_dm_done", {31'd0, dm_done}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Minimum-latency load.
        phys[32'h100] = 32'hDEADBEEF;
        refm[32'h100] = 32'hDEADBEEF;
        do_dm(3'd2, 32'h100, 32'd0, 0, 1);
        check("t1_lw", dm_rdata, 32'hDEADBEEF);

        // Sign/zero extension of sub-word loads.
        phys[32'h100] = 32'h80FFFF7F;
        refm[32'h100] = 32'h80FFFF7F;
        do_dm(3'd0, 32'h103, 32'd0, 0, 1);
        check("t2_lb", dm_rdata, 32'hFFFFFF80);
        do_dm(3'd3, 32'h103, 32'd0, 1, 2);
        check("t2_lbu", dm_rdata, 32'h00000080);
        do_dm(3'd1, 32'h102, 32'd0, 0, 1);
        check("t2_lh", dm_rdata, 32'hFFFF80FF);

        // Stores with mem_ready held off for 3 cycles.
        do_dm(3'd5, 32'h101, 32'h000000AB, 3, 1);
        check("t3_sb_we", {28'd0, last_we}, 32'h2);
        check("t3_sb_wd", last_wd, 32'hABABABAB);
        do_dm(3'd6, 32'h102, 32'h00001234, 3, 1);
        check("t3_sh_we", {28'd0, last_we}, 32'hC);
        check("t3_sh_wd", last_wd, 32'h12341234);
        do_dm(3'd2, 32'h100, 32'd0, 0, 1);
        check("t3_readback", dm_rdata, 32'h1234AB7F);

        // Misaligned word store.
        do_dm(3'd7, 32'h102, 32'hCAFEF00D, 0, 1);
`ifndef MEM_MISALIGN_TRAP_EN
        check("t6_sw_we", {28'd0, last_we}, 32'hF);
`endif
        do_dm(3'd2, 32'h100, 32'd0, 0, 1);

        // Both requesters held: four data grants, then one fetch.
        ready_wait = 0;
        rv_lat = 1;
        if_addr = 32'h400;
        dm_addr = 32'h404;
        dm_ldst = 3'd2;
        if_req = 1'b1;
        dm_req = 1'b1;
        nev = 0;
        k = 0;
        while (nev < 10 && k < 300) begin
            @(negedge clk);
            k++;
            if (dm_done === 1'b1 || if_done === 1'b1) begin
                check($sformatf("arb_grant_%0d", nev), {31'd0, dm_done}, (nev % 5 == 4) ? 32'd0 : 32'd1);
                check("arb_exclusive", {31'd0, dm_done & if_done}, 32'd0);
                nev++;
            end
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("arb_events", nev, 10);
        @(negedge clk);

        // Reset while waiting for read data; late rvalid must be discarded.
        ready_wait = 0;
        rv_lat = 4;
        dm_addr = 32'h200;
        dm_ldst = 3'd2;
        dm_req = 1'b1;
        k = 0;
        while (mem_valid !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t5_issue_seen", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        dm_req = 1'b0;
        #1;
        check("t5_rst_stall", {31'd0, stall}, 32'd0);
        check("t5_rst_valid", {31'd0, mem_valid}, 32'd0);
        check("t5_rst_dm_rdata", dm_rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dm_done === 1'b1 || if_done === 1'b1 || stall === 1'b1 || mem_valid === 1'b1)
                seen = 1'b1;
        end
        check("t5_quiet_after_rst", {31'd0, seen}, 32'd0);
        do_dm(3'd2, 32'h200, 32'd0, 0, 1);

        // Randomized single accesses against the reference memory.
        for (int i = 0; i < 40; i++) begin
            int unsigned w = $urandom_range(0, 3);
            int unsigned rl = $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0)
                do_if(32'h300 + 4 * $urandom_range(0, 15), w, rl);
            else
                do_dm(3'($urandom_range(0, 7)), 32'h300 + $urandom_range(0, 63), $urandom, w, rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
